// File: rtl/pe_bypass_ctrl.sv
// ---------------------------------------------------------------------------
// pe_bypass_ctrl
//
// Per-PE operand bypass controller. Remembers the destination of the
// instruction currently in ID and compares it against the sources of the
// instruction issuing in IF. It produces:
//   - registered bypass enables/selects used by the bypass network in ID
//     (one cycle after the IF compare)
//   - a combinational load-use stall back to IF
//   - a saturating count of hazard-stall cycles
//
// Optional build macro:
//   PE_BP_MUL_STALL_EN  - MUL results are treated as 2-cycle. A MUL-sourced
//                         match stalls like a load and MUL is never forwarded.
//                         When undefined, MUL results are forwarded from EX.
//
// Parameters:
//   RF_IDX_W   register index width (default DEF_RF_INDEX_WIDTH = 5)
//   CNT_W      stall counter width
//
// Ports:
//   iClk, iReset               clock, asynchronous active-high reset
//   iIF_Valid                  IF holds a valid instruction
//   iIF_RF_Read_Addr_A/B       source register indices
//   iIF_Read_En_A/B            source actually used
//   iIF_Dest_Write             instruction writes the RF
//   iIF_Dest_Addr              destination index
//   iIF_Dest_Src               producing unit (ALU/MUL/LSU/SHADOW)
//   iStall                     external pipeline freeze
//   iFlush                     kill in-flight instructions
//   iStall_Count_Clr           synchronous counter clear
//   oIF_Stall                  load-use hazard (combinational)
//   oBP_Bypass_Read_A/B        operand taken from EX result (registered)
//   oBP_Bypass_Sel_A/B         EX source select (registered)
//   oStall_Count               saturating hazard-stall count
// ---------------------------------------------------------------------------
`ifndef DEF_RF_INDEX_WIDTH
`define DEF_RF_INDEX_WIDTH 5
`endif

module pe_bypass_ctrl #(
    parameter int RF_IDX_W = `DEF_RF_INDEX_WIDTH,
    parameter int CNT_W    = 16
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic                iIF_Valid,
    input  logic [RF_IDX_W-1:0] iIF_RF_Read_Addr_A,
    input  logic [RF_IDX_W-1:0] iIF_RF_Read_Addr_B,
    input  logic                iIF_Read_En_A,
    input  logic                iIF_Read_En_B,
    input  logic                iIF_Dest_Write,
    input  logic [RF_IDX_W-1:0] iIF_Dest_Addr,
    input  logic [1:0]          iIF_Dest_Src,
    input  logic                iStall,
    input  logic                iFlush,
    input  logic                iStall_Count_Clr,
    output logic                oIF_Stall,
    output logic                oBP_Bypass_Read_A,
    output logic                oBP_Bypass_Read_B,
    output logic [1:0]          oBP_Bypass_Sel_A,
    output logic [1:0]          oBP_Bypass_Sel_B,
    output logic [CNT_W-1:0]    oStall_Count
);

    // Producer encodings (SHADOW = 2'b11 is forwarded like ALU results)
    localparam logic [1:0] RISC24_BYPASS_SRC_ALU = 2'b00;
    localparam logic [1:0] RISC24_BYPASS_SRC_LSU = 2'b10;
`ifdef PE_BP_MUL_STALL_EN
    localparam logic [1:0] RISC24_BYPASS_SRC_MUL = 2'b01;
`endif

    // ID record: producer that will be in EX when the IF instruction is in ID
    logic                id_vld_q, id_vld_d;
    logic [RF_IDX_W-1:0] id_dst_q, id_dst_d;
    logic [1:0]          id_src_q, id_src_d;

    logic                rd_a_q, rd_a_d;
    logic                rd_b_q, rd_b_d;
    logic [1:0]          sel_a_q, sel_a_d;
    logic [1:0]          sel_b_q, sel_b_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic id_fwd_ok;
    logic match_a;
    logic match_b;
    logic stall_src;
    logic hazard;

    // r0/r1 are never forwarded, so a producer writing them is invisible here
    assign id_fwd_ok = id_vld_q && (id_dst_q > RF_IDX_W'(1));

    assign match_a = iIF_Valid && iIF_Read_En_A && id_fwd_ok &&
                     (id_dst_q == iIF_RF_Read_Addr_A);
    assign match_b = iIF_Valid && iIF_Read_En_B && id_fwd_ok &&
                     (id_dst_q == iIF_RF_Read_Addr_B);

    // Producers whose result is not ready at the end of EX
`ifdef PE_BP_MUL_STALL_EN
    assign stall_src = (id_src_q == RISC24_BYPASS_SRC_LSU) ||
                       (id_src_q == RISC24_BYPASS_SRC_MUL);
`else
    assign stall_src = (id_src_q == RISC24_BYPASS_SRC_LSU);
`endif

    assign hazard    = (match_a || match_b) && stall_src;
    assign oIF_Stall = hazard && !iFlush;

    always_comb begin
        id_vld_d = id_vld_q;
        id_dst_d = id_dst_q;
        id_src_d = id_src_q;
        rd_a_d   = rd_a_q;
        rd_b_d   = rd_b_q;
        sel_a_d  = sel_a_q;
        sel_b_d  = sel_b_q;

        if (iFlush) begin
            id_vld_d = 1'b0;
            rd_a_d   = 1'b0;
            rd_b_d   = 1'b0;
            sel_a_d  = RISC24_BYPASS_SRC_ALU;
            sel_b_d  = RISC24_BYPASS_SRC_ALU;
        end else if (!iStall) begin
            if (hazard) begin
                // Bubble: the consumer retries next cycle against an empty ID,
                // and the load reaches WB in time for RF write-port forwarding.
                id_vld_d = 1'b0;
                rd_a_d   = 1'b0;
                rd_b_d   = 1'b0;
                sel_a_d  = RISC24_BYPASS_SRC_ALU;
                sel_b_d  = RISC24_BYPASS_SRC_ALU;
            end else begin
                id_vld_d = iIF_Valid && iIF_Dest_Write;
                id_dst_d = iIF_Dest_Addr;
                id_src_d = iIF_Dest_Src;
                rd_a_d   = match_a;
                rd_b_d   = match_b;
                sel_a_d  = match_a ? id_src_q : RISC24_BYPASS_SRC_ALU;
                sel_b_d  = match_b ? id_src_q : RISC24_BYPASS_SRC_ALU;
            end
        end

        cnt_d = cnt_q;
        if (iStall_Count_Clr) begin
            cnt_d = '0;
        end else if (oIF_Stall && !iStall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            id_vld_q <= 1'b0;
            id_dst_q <= '0;
            id_src_q <= RISC24_BYPASS_SRC_ALU;
            rd_a_q   <= 1'b0;
            rd_b_q   <= 1'b0;
            sel_a_q  <= RISC24_BYPASS_SRC_ALU;
            sel_b_q  <= RISC24_BYPASS_SRC_ALU;
            cnt_q    <= '0;
        end else begin
            id_vld_q <= id_vld_d;
            id_dst_q <= id_dst_d;
            id_src_q <= id_src_d;
            rd_a_q   <= rd_a_d;
            rd_b_q   <= rd_b_d;
            sel_a_q  <= sel_a_d;
            sel_b_q  <= sel_b_d;
            cnt_q    <= cnt_d;
        end
    end

    assign oBP_Bypass_Read_A = rd_a_q;
    assign oBP_Bypass_Read_B = rd_b_q;
    assign oBP_Bypass_Sel_A  = sel_a_q;
    assign oBP_Bypass_Sel_B  = sel_b_q;
    assign oStall_Count      = cnt_q;

endmodule

// File: tb/tb_pe_bypass_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pe_bypass_ctrl
//
// Scenario bench for pe_bypass_ctrl. Each task builds a short stimulus table;
// the expected bypass word for each issued instruction is queued when it is
// driven and popped one edge later when the registered outputs appear.
// The counter is instantiated 8 bits wide so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_pe_bypass_ctrl;

    localparam int         CW      = 8;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [1:0] ALU = 2'b00;
    localparam logic [1:0] MUL = 2'b01;
    localparam logic [1:0] LSU = 2'b10;
    localparam logic [1:0] SHD = 2'b11;

    // {read_a, read_b, sel_a, sel_b}
    typedef logic [5:0] bp_t;
    localparam bp_t BP0 = 6'b0;

    typedef struct {
        logic       v;
        logic [4:0] ra;
        logic       ea;
        logic [4:0] rb;
        logic       eb;
        logic       wr;
        logic [4:0] dst;
        logic [1:0] src;
        logic       st;
        logic       fl;
        logic       clr;
        logic       xs;
        bp_t        xbp;
    } step_t;

    logic          iClk;
    logic          iReset;
    logic          iIF_Valid;
    logic [4:0]    iIF_RF_Read_Addr_A;
    logic [4:0]    iIF_RF_Read_Addr_B;
    logic          iIF_Read_En_A;
    logic          iIF_Read_En_B;
    logic          iIF_Dest_Write;
    logic [4:0]    iIF_Dest_Addr;
    logic [1:0]    iIF_Dest_Src;
    logic          iStall;
    logic          iFlush;
    logic          iStall_Count_Clr;
    logic          oIF_Stall;
    logic          oBP_Bypass_Read_A;
    logic          oBP_Bypass_Read_B;
    logic [1:0]    oBP_Bypass_Sel_A;
    logic [1:0]    oBP_Bypass_Sel_B;
    logic [CW-1:0] oStall_Count;

    int            vectors;
    int            miscompares;
    logic [CW-1:0] exp_cnt;
    bp_t           exp_q[$];

    pe_bypass_ctrl #(.RF_IDX_W(5), .CNT_W(CW)) dut (
        .iClk               (iClk),
        .iReset             (iReset),
        .iIF_Valid          (iIF_Valid),
        .iIF_RF_Read_Addr_A (iIF_RF_Read_Addr_A),
        .iIF_RF_Read_Addr_B (iIF_RF_Read_Addr_B),
        .iIF_Read_En_A      (iIF_Read_En_A),
        .iIF_Read_En_B      (iIF_Read_En_B),
        .iIF_Dest_Write     (iIF_Dest_Write),
        .iIF_Dest_Addr      (iIF_Dest_Addr),
        .iIF_Dest_Src       (iIF_Dest_Src),
        .iStall             (iStall),
        .iFlush             (iFlush),
        .iStall_Count_Clr   (iStall_Count_Clr),
        .oIF_Stall          (oIF_Stall),
        .oBP_Bypass_Read_A  (oBP_Bypass_Read_A),
        .oBP_Bypass_Read_B  (oBP_Bypass_Read_B),
        .oBP_Bypass_Sel_A   (oBP_Bypass_Sel_A),
        .oBP_Bypass_Sel_B   (oBP_Bypass_Sel_B),
        .oStall_Count       (oStall_Count)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #1ms;
        $display("FAIL watchdog simulation did not finish, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    function automatic step_t mk(logic v, logic [4:0] ra, logic ea, logic [4:0] rb, logic eb,
                                 logic wr, logic [4:0] dst, logic [1:0] src,
                                 logic st, logic fl, logic clr, logic xs, bp_t xbp);
        step_t s;
        s.v = v; s.ra = ra; s.ea = ea; s.rb = rb; s.eb = eb;
        s.wr = wr; s.dst = dst; s.src = src;
        s.st = st; s.fl = fl; s.clr = clr; s.xs = xs; s.xbp = xbp;
        return s;
    endfunction

    task automatic apply(input step_t s);
        iIF_Valid          = s.v;
        iIF_RF_Read_Addr_A = s.ra;
        iIF_Read_En_A      = s.ea;
        iIF_RF_Read_Addr_B = s.rb;
        iIF_Read_En_B      = s.eb;
        iIF_Dest_Write     = s.wr;
        iIF_Dest_Addr      = s.dst;
        iIF_Dest_Src       = s.src;
        iStall             = s.st;
        iFlush             = s.fl;
        iStall_Count_Clr   = s.clr;
    endtask

    task automatic test_reset();
        bp_t got_bp;
        apply(mk(1, 5'd5, 1, 5'd5, 1, 1, 5'd5, LSU, 0, 0, 0, 0, BP0));
        iReset = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        got_bp = {oBP_Bypass_Read_A, oBP_Bypass_Read_B, oBP_Bypass_Sel_A, oBP_Bypass_Sel_B};
        vectors++;
        if (got_bp !== BP0) begin
            miscompares++;
            $display("FAIL reset bypass got %b want %b", got_bp, BP0);
        end
        vectors++;
        if (oIF_Stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset oIF_Stall got %b want 0", oIF_Stall);
        end
        vectors++;
        if (oStall_Count !== '0) begin
            miscompares++;
            $display("FAIL reset oStall_Count got %0d want 0", oStall_Count);
        end
        $display("reset bp=%b stall=%b cnt=%0d", got_bp, oIF_Stall, oStall_Count);
        apply(mk(0, 0, 0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, BP0));
        iReset  = 1'b0;
        exp_cnt = '0;
        @(posedge iClk);
        #1;
    endtask

    task automatic test_forwarding();
        step_t s[$];
        bp_t   got_bp, exp_bp;
        s.push_back(mk(0, 0,     0, 0,     0, 0, 0,     ALU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 0,     0, 0,     0, 1, 5'd5,  ALU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 5'd5,  1, 0,     0, 0, 0,     ALU, 0, 0, 0, 0, {1'b1, 1'b0, ALU, ALU}));
        s.push_back(mk(1, 0,     0, 0,     0, 1, 5'd1,  ALU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 5'd1,  1, 5'd1,  1, 1, 5'd9,  ALU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 5'd9,  0, 5'd3,  1, 1, 5'd2,  ALU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 5'd2,  1, 0,     0, 1, 5'd20, SHD, 0, 0, 0, 0, {1'b1, 1'b0, ALU, ALU}));
        s.push_back(mk(1, 5'd0,  1, 5'd20, 1, 1, 5'd11, ALU, 0, 0, 0, 0, {1'b0, 1'b1, ALU, SHD}));
        s.push_back(mk(0, 5'd11, 1, 5'd11, 1, 0, 0,     ALU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 0,     0, 0,     0, 1, 5'd4,  MUL, 0, 0, 0, 0, BP0));
`ifdef PE_BP_MUL_STALL_EN
        s.push_back(mk(1, 5'd4,  1, 5'd4,  1, 0, 0,     ALU, 0, 0, 0, 1, BP0));
        s.push_back(mk(1, 5'd4,  1, 5'd4,  1, 0, 0,     ALU, 0, 0, 0, 0, BP0));
`else
        s.push_back(mk(1, 5'd4,  1, 5'd4,  1, 0, 0,     ALU, 0, 0, 0, 0, {1'b1, 1'b1, MUL, MUL}));
        s.push_back(mk(0, 0,     0, 0,     0, 0, 0,     ALU, 0, 0, 0, 0, BP0));
`endif
        foreach (s[i]) begin
            apply(s[i]);
            #1;
            vectors++;
            if (oIF_Stall !== s[i].xs) begin
                miscompares++;
                $display("FAIL fwd[%0d] oIF_Stall got %b want %b", i, oIF_Stall, s[i].xs);
            end
            exp_q.push_back(s[i].xbp);
            if (s[i].clr) exp_cnt = '0;
            else if (s[i].xs && !s[i].st && exp_cnt != CNT_MAX) exp_cnt++;
            @(posedge iClk);
            #1;
            exp_bp = exp_q.pop_front();
            got_bp = {oBP_Bypass_Read_A, oBP_Bypass_Read_B, oBP_Bypass_Sel_A, oBP_Bypass_Sel_B};
            vectors++;
            if (got_bp !== exp_bp) begin
                miscompares++;
                $display("FAIL fwd[%0d] bypass got %b want %b", i, got_bp, exp_bp);
            end
            vectors++;
            if (oStall_Count !== exp_cnt) begin
                miscompares++;
                $display("FAIL fwd[%0d] oStall_Count got %0d want %0d", i, oStall_Count, exp_cnt);
            end
            $display("fwd[%0d] bp=%b cnt=%0d", i, got_bp, oStall_Count);
        end
    endtask

    task automatic test_load_use();
        step_t s[$];
        bp_t   got_bp, exp_bp;
        s.push_back(mk(0, 0,    0, 0,    0, 0, 0,    ALU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 0,    0, 0,    0, 1, 5'd7, LSU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 5'd2, 1, 5'd7, 1, 0, 0,    ALU, 0, 0, 0, 1, BP0));
        s.push_back(mk(1, 5'd2, 1, 5'd7, 1, 0, 0,    ALU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 0,    0, 0,    0, 1, 5'd1, LSU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 5'd1, 1, 5'd1, 1, 0, 0,    ALU, 0, 0, 0, 0, BP0));
        foreach (s[i]) begin
            apply(s[i]);
            #1;
            vectors++;
            if (oIF_Stall !== s[i].xs) begin
                miscompares++;
                $display("FAIL ldu[%0d] oIF_Stall got %b want %b", i, oIF_Stall, s[i].xs);
            end
            exp_q.push_back(s[i].xbp);
            if (s[i].clr) exp_cnt = '0;
            else if (s[i].xs && !s[i].st && exp_cnt != CNT_MAX) exp_cnt++;
            @(posedge iClk);
            #1;
            exp_bp = exp_q.pop_front();
            got_bp = {oBP_Bypass_Read_A, oBP_Bypass_Read_B, oBP_Bypass_Sel_A, oBP_Bypass_Sel_B};
            vectors++;
            if (got_bp !== exp_bp) begin
                miscompares++;
                $display("FAIL ldu[%0d] bypass got %b want %b", i, got_bp, exp_bp);
            end
            vectors++;
            if (oStall_Count !== exp_cnt) begin
                miscompares++;
                $display("FAIL ldu[%0d] oStall_Count got %0d want %0d", i, oStall_Count, exp_cnt);
            end
            $display("ldu[%0d] stall=%b bp=%b cnt=%0d", i, s[i].xs, got_bp, oStall_Count);
        end
    endtask

    task automatic test_flush_stall();
        step_t s[$];
        bp_t   got_bp, exp_bp;
        s.push_back(mk(0, 0,     0, 0,    0, 0, 0,     ALU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 0,     0, 0,    0, 1, 5'd6,  ALU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 5'd6,  1, 0,    0, 1, 5'd3,  LSU, 0, 0, 0, 0, {1'b1, 1'b0, ALU, ALU}));
        // flush with stall also high: flush wins, no load-use stall reported
        s.push_back(mk(1, 5'd3,  1, 5'd3, 1, 0, 0,     ALU, 1, 1, 0, 0, BP0));
        s.push_back(mk(1, 5'd3,  1, 5'd3, 1, 0, 0,     ALU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 0,     0, 0,    0, 1, 5'd8,  ALU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 5'd8,  1, 5'd8, 1, 1, 5'd10, LSU, 0, 0, 0, 0, {1'b1, 1'b1, ALU, ALU}));
        for (int k = 0; k < 3; k++)
            s.push_back(mk(1, 5'd10, 1, 0, 0, 0, 0, ALU, 1, 0, 0, 1, {1'b1, 1'b1, ALU, ALU}));
        s.push_back(mk(1, 5'd10, 1, 0,    0, 0, 0,     ALU, 0, 0, 0, 1, BP0));
        s.push_back(mk(1, 5'd10, 1, 0,    0, 0, 0,     ALU, 0, 0, 0, 0, BP0));
        foreach (s[i]) begin
            apply(s[i]);
            #1;
            vectors++;
            if (oIF_Stall !== s[i].xs) begin
                miscompares++;
                $display("FAIL flst[%0d] oIF_Stall got %b want %b", i, oIF_Stall, s[i].xs);
            end
            exp_q.push_back(s[i].xbp);
            if (s[i].clr) exp_cnt = '0;
            else if (s[i].xs && !s[i].st && exp_cnt != CNT_MAX) exp_cnt++;
            @(posedge iClk);
            #1;
            exp_bp = exp_q.pop_front();
            got_bp = {oBP_Bypass_Read_A, oBP_Bypass_Read_B, oBP_Bypass_Sel_A, oBP_Bypass_Sel_B};
            vectors++;
            if (got_bp !== exp_bp) begin
                miscompares++;
                $display("FAIL flst[%0d] bypass got %b want %b", i, got_bp, exp_bp);
            end
            vectors++;
            if (oStall_Count !== exp_cnt) begin
                miscompares++;
                $display("FAIL flst[%0d] oStall_Count got %0d want %0d", i, oStall_Count, exp_cnt);
            end
            $display("flst[%0d] stall=%b bp=%b cnt=%0d", i, s[i].xs, got_bp, oStall_Count);
        end
    endtask

    task automatic test_counter_sat();
        step_t s[$];
        bp_t   got_bp, exp_bp;
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, ALU, 0, 0, 1, 0, BP0));
        for (int k = 0; k < int'(CNT_MAX) + 3; k++) begin
            s.push_back(mk(1, 0,    0, 0,    0, 1, 5'd7, LSU, 0, 0, 0, 0, BP0));
            s.push_back(mk(1, 5'd0, 0, 5'd7, 1, 0, 0,    ALU, 0, 0, 0, 1, BP0));
            s.push_back(mk(1, 5'd0, 0, 5'd7, 1, 0, 0,    ALU, 0, 0, 0, 0, BP0));
        end
        // clear coincides with a stall: clear wins
        s.push_back(mk(1, 0,    0, 0,    0, 1, 5'd7, LSU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 5'd0, 0, 5'd7, 1, 0, 0,    ALU, 0, 0, 1, 1, BP0));
        s.push_back(mk(0, 0,    0, 0,    0, 0, 0,    ALU, 0, 0, 0, 0, BP0));
        foreach (s[i]) begin
            apply(s[i]);
            #1;
            vectors++;
            if (oIF_Stall !== s[i].xs) begin
                miscompares++;
                $display("FAIL cnt[%0d] oIF_Stall got %b want %b", i, oIF_Stall, s[i].xs);
            end
            exp_q.push_back(s[i].xbp);
            if (s[i].clr) exp_cnt = '0;
            else if (s[i].xs && !s[i].st && exp_cnt != CNT_MAX) exp_cnt++;
            @(posedge iClk);
            #1;
            exp_bp = exp_q.pop_front();
            got_bp = {oBP_Bypass_Read_A, oBP_Bypass_Read_B, oBP_Bypass_Sel_A, oBP_Bypass_Sel_B};
            vectors++;
            if (got_bp !== exp_bp) begin
                miscompares++;
                $display("FAIL cnt[%0d] bypass got %b want %b", i, got_bp, exp_bp);
            end
            vectors++;
            if (oStall_Count !== exp_cnt) begin
                miscompares++;
                $display("FAIL cnt[%0d] oStall_Count got %0d want %0d", i, oStall_Count, exp_cnt);
            end
            $display("cnt[%0d] stall=%b cnt=%0d", i, s[i].xs, oStall_Count);
            if (i == 3 * (int'(CNT_MAX) + 3)) begin
                vectors++;
                if (oStall_Count !== CNT_MAX) begin
                    miscompares++;
                    $display("FAIL cnt_sat oStall_Count got %0d want %0d", oStall_Count, CNT_MAX);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t s[$];
        bp_t   got_bp, exp_bp;
        s.push_back(mk(0, 0,     0, 0,     0, 0, 0,     ALU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 0,     0, 0,     0, 1, 5'd12, LSU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 5'd0,  0, 5'd12, 1, 0, 0,     ALU, 0, 0, 0, 1, BP0));
        s.push_back(mk(1, 5'd0,  0, 5'd12, 1, 0, 0,     ALU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 0,     0, 0,     0, 1, 5'd5,  ALU, 0, 0, 0, 0, BP0));
        s.push_back(mk(1, 5'd5,  1, 0,     0, 1, 5'd3,  LSU, 0, 0, 0, 0, {1'b1, 1'b0, ALU, ALU}));
        foreach (s[i]) begin
            apply(s[i]);
            #1;
            vectors++;
            if (oIF_Stall !== s[i].xs) begin
                miscompares++;
                $display("FAIL rmid[%0d] oIF_Stall got %b want %b", i, oIF_Stall, s[i].xs);
            end
            exp_q.push_back(s[i].xbp);
            if (s[i].clr) exp_cnt = '0;
            else if (s[i].xs && !s[i].st && exp_cnt != CNT_MAX) exp_cnt++;
            @(posedge iClk);
            #1;
            exp_bp = exp_q.pop_front();
            got_bp = {oBP_Bypass_Read_A, oBP_Bypass_Read_B, oBP_Bypass_Sel_A, oBP_Bypass_Sel_B};
            vectors++;
            if (got_bp !== exp_bp) begin
                miscompares++;
                $display("FAIL rmid[%0d] bypass got %b want %b", i, got_bp, exp_bp);
            end
            vectors++;
            if (oStall_Count !== exp_cnt) begin
                miscompares++;
                $display("FAIL rmid[%0d] oStall_Count got %0d want %0d", i, oStall_Count, exp_cnt);
            end
            $display("rmid[%0d] stall=%b bp=%b cnt=%0d", i, s[i].xs, got_bp, oStall_Count);
        end
        // consumer of the load in ID: stalling when reset hits mid-cycle
        apply(mk(1, 5'd3, 1, 0, 0, 0, 0, ALU, 0, 0, 0, 1, BP0));
        #1;
        vectors++;
        if (oIF_Stall !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_pre oIF_Stall got %b want 1", oIF_Stall);
        end
        iReset = 1'b1;
        #1;
        exp_cnt = '0;
        got_bp  = {oBP_Bypass_Read_A, oBP_Bypass_Read_B, oBP_Bypass_Sel_A, oBP_Bypass_Sel_B};
        vectors++;
        if ({got_bp, oIF_Stall, oStall_Count} !== {BP0, 1'b0, exp_cnt}) begin
            miscompares++;
            $display("FAIL rmid_async bp/stall/cnt got %b/%b/%0d want %b/0/0",
                     got_bp, oIF_Stall, oStall_Count, BP0);
        end
        $display("rmid_async bp=%b stall=%b cnt=%0d", got_bp, oIF_Stall, oStall_Count);
        iReset = 1'b0;
        #1;
        vectors++;
        if (oIF_Stall !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_post oIF_Stall got %b want 0", oIF_Stall);
        end
        exp_q.push_back(BP0);
        @(posedge iClk);
        #1;
        exp_bp = exp_q.pop_front();
        got_bp = {oBP_Bypass_Read_A, oBP_Bypass_Read_B, oBP_Bypass_Sel_A, oBP_Bypass_Sel_B};
        vectors++;
        if (got_bp !== exp_bp) begin
            miscompares++;
            $display("FAIL rmid_post bypass got %b want %b", got_bp, exp_bp);
        end
        $display("rmid_post bp=%b stall=%b", got_bp, oIF_Stall);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_cnt     = '0;
        iReset      = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, BP0));
        test_reset();
        test_forwarding();
        test_load_use();
        test_flush_stall();
        test_counter_sat();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
